// File: rtl/vram_pkg.sv
// Shared VRAM geometry, port identifiers and the read-tag format used by the
// arbiter and its tag pipeline.
package vram_pkg;

  localparam int VRAM_DATA_W = 32;
  localparam int VRAM_NB_COL = 4;
  localparam int VRAM_COL_W  = 8;

  typedef enum logic {
    PORT_VIDEO = 1'b0,
    PORT_CPU   = 1'b1
  } port_e;

  typedef struct packed {
    logic       valid;
    port_e      port;
    logic [1:0] lane;
  } rd_tag_t;

  localparam int RD_TAG_W = $bits(rd_tag_t);

  function automatic rd_tag_t make_tag(input logic valid, input port_e port, input logic [1:0] lane);
    rd_tag_t t;
    t.valid = valid;
    t.port  = port;
    t.lane  = lane;
    return t;
  endfunction

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Latency-matched shift register of read tags; the tail stage lines up with
// the cycle in which the RAM presents the data for that tag.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RD_TAG_W-1:0] tag_in,
  output logic [RD_TAG_W-1:0] tag_out
);

  logic [RD_TAG_W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vram_access_arbiter.sv
// Two-port request arbiter in front of the single-port byte-write VRAM:
// video fetch has priority, the CPU port is protected by a starvation counter.
module vram_access_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 17,
  parameter int RAM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_req,
  input  logic [ADDR_WIDTH-3:0]    p0_addr,
  output logic                     p0_ack,
  output logic [VRAM_DATA_W-1:0]   p0_rdata,
  output logic                     p0_rvalid,
  input  logic                     p1_req,
  input  logic                     p1_wr,
  input  logic [ADDR_WIDTH-1:0]    p1_addr,
  input  logic [VRAM_COL_W-1:0]    p1_wdata,
  output logic                     p1_ack,
  output logic [VRAM_COL_W-1:0]    p1_rdata,
  output logic                     p1_rvalid,
  output logic [ADDR_WIDTH-3:0]    ram_addr,
  output logic [VRAM_DATA_W-1:0]   ram_wrdata,
  output logic [VRAM_NB_COL-1:0]   ram_wrbytesel,
  input  logic [VRAM_DATA_W-1:0]   ram_rddata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]           starve_cnt;
  logic                 grant_p0, grant_p1;
  rd_tag_t              tag_push, tag_ret;
  logic [RD_TAG_W-1:0]  tag_ret_bits;
  logic                 p0_rvalid_q, p1_rvalid_q;
  logic [VRAM_DATA_W-1:0] p0_rdata_q;
  logic [VRAM_COL_W-1:0]  p1_rdata_q;

  // No grants while in reset so nothing is acked that would be discarded.
  assign grant_p1 = !rst && p1_req && (!p0_req || starve_cnt == LIMIT);
  assign grant_p0 = !rst && p0_req && !grant_p1;
  assign p0_ack   = grant_p0;
  assign p1_ack   = grant_p1;

  always_ff @(posedge clk) begin
    if (rst || !p1_req || grant_p1) starve_cnt <= '0;
    else if (starve_cnt != LIMIT)   starve_cnt <= starve_cnt + 4'd1;
  end

  always_comb begin
    ram_addr      = p0_addr;
    ram_wrdata    = '0;
    ram_wrbytesel = '0;
    tag_push      = make_tag(1'b0, PORT_VIDEO, 2'b00);
    if (grant_p0) begin
      tag_push = make_tag(1'b1, PORT_VIDEO, 2'b00);
    end else if (grant_p1) begin
      ram_addr = p1_addr[ADDR_WIDTH-1:2];
      if (p1_wr) begin
        ram_wrdata    = {VRAM_NB_COL{p1_wdata}};
        ram_wrbytesel = 4'b0001 << p1_addr[1:0];
      end else begin
        tag_push = make_tag(1'b1, PORT_CPU, p1_addr[1:0]);
      end
    end
  end

  vram_rd_tag_pipe #(.DEPTH(RAM_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_push),
    .tag_out (tag_ret_bits)
  );

  assign tag_ret = rd_tag_t'(tag_ret_bits);

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_rvalid_q <= tag_ret.valid && tag_ret.port == PORT_VIDEO;
      p1_rvalid_q <= tag_ret.valid && tag_ret.port == PORT_CPU;
      if (tag_ret.valid && tag_ret.port == PORT_VIDEO) p0_rdata_q <= ram_rddata;
      if (tag_ret.valid && tag_ret.port == PORT_CPU)
        p1_rdata_q <= ram_rddata[{tag_ret.lane, 3'b000} +: VRAM_COL_W];
    end
  end

  // Masked during reset so a return registered just before rst never escapes.
  assign p0_rvalid = p0_rvalid_q && !rst;
  assign p1_rvalid = p1_rvalid_q && !rst;
  assign p0_rdata  = rst ? '0 : p0_rdata_q;
  assign p1_rdata  = rst ? '0 : p1_rdata_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench: one arbiter with an output-registered RAM (latency 2) and
// one with a low-latency RAM (latency 1), driven by the same requests.
module tb_vram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p1_req, p1_wr;
  logic [14:0] p0_addr;
  logic [16:0] p1_addr;
  logic [7:0]  p1_wdata;

  logic        a_p0_ack, a_p0_rvalid, a_p1_ack, a_p1_rvalid;
  logic [31:0] a_p0_rdata, a_wrdata, a_rddata;
  logic [7:0]  a_p1_rdata;
  logic [14:0] a_addr;
  logic [3:0]  a_sel;

  logic        b_p0_ack, b_p0_rvalid, b_p1_ack, b_p1_rvalid;
  logic [31:0] b_p0_rdata, b_wrdata, b_rddata;
  logic [7:0]  b_p1_rdata;
  logic [14:0] b_addr;
  logic [3:0]  b_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_access_arbiter #(.ADDR_WIDTH(17), .RAM_LATENCY(2), .STARVE_LIMIT(4)) u_lat2 (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata), .p0_rvalid(a_p0_rvalid),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata), .p1_rvalid(a_p1_rvalid),
    .ram_addr(a_addr), .ram_wrdata(a_wrdata), .ram_wrbytesel(a_sel), .ram_rddata(a_rddata)
  );

  vram_access_arbiter #(.ADDR_WIDTH(17), .RAM_LATENCY(1), .STARVE_LIMIT(4)) u_lat1 (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata), .p0_rvalid(b_p0_rvalid),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata), .p1_rvalid(b_p1_rvalid),
    .ram_addr(b_addr), .ram_wrdata(b_wrdata), .ram_wrbytesel(b_sel), .ram_rddata(b_rddata)
  );

  // Write-first byte-write RAM models (16 words are enough for the vectors).
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] a_r1, a_r2, b_r1;

  always @(posedge clk) begin : ram_a
    logic [31:0] w;
    w = mem_a[a_addr[3:0]];
    for (int k = 0; k < 4; k++) if (a_sel[k]) w[8*k +: 8] = a_wrdata[8*k +: 8];
    mem_a[a_addr[3:0]] <= w;
    a_r1 <= w;
    a_r2 <= a_r1;
  end
  assign a_rddata = a_r2;

  always @(posedge clk) begin : ram_b
    logic [31:0] w;
    w = mem_b[b_addr[3:0]];
    for (int k = 0; k < 4; k++) if (b_sel[k]) w[8*k +: 8] = b_wrdata[8*k +: 8];
    mem_b[b_addr[3:0]] <= w;
    b_r1 <= w;
  end
  assign b_rddata = b_r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [31:0] exp_w [4];

  initial begin
    for (int k = 0; k < 16; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    mem_a[0] = 32'hA0B0C0D0; mem_b[0] = 32'hA0B0C0D0;
    mem_a[1] = 32'h11223344; mem_b[1] = 32'h11223344;
    mem_a[2] = 32'hCAFEBABE; mem_b[2] = 32'hCAFEBABE;
    mem_a[3] = 32'h0BADF00D; mem_b[3] = 32'h0BADF00D;
    // Word 1 after the byte write of A5 into lane 1.
    exp_w[0] = 32'hA0B0C0D0;
    exp_w[1] = 32'h1122A544;
    exp_w[2] = 32'hCAFEBABE;
    exp_w[3] = 32'h0BADF00D;

    rst = 1'b1; p0_req = 0; p0_addr = '0; p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;

    // Reset state, during and one cycle after rst
    step(); #1;
    chk("rst_p0_rvalid", 32'(a_p0_rvalid), 0);
    chk("rst_p1_rvalid", 32'(a_p1_rvalid), 0);
    chk("rst_p0_rdata", a_p0_rdata, 0);
    chk("rst_p1_rdata", 32'(a_p1_rdata), 0);
    step(); rst = 1'b0; #1;
    step(); #1;
    chk("post_rst_p0_rvalid", 32'(a_p0_rvalid), 0);
    chk("post_rst_p1_rvalid", 32'(a_p1_rvalid), 0);
    chk("post_rst_p0_rdata", a_p0_rdata, 0);
    chk("post_rst_p1_rdata", 32'(a_p1_rdata), 0);

    // Single CPU byte write
    step(); p1_req = 1; p1_wr = 1; p1_addr = 17'h00005; p1_wdata = 8'hA5; #1;
    chk("wr_p1_ack", 32'(a_p1_ack), 1);
    chk("wr_p0_ack", 32'(a_p0_ack), 0);
    chk("wr_ram_addr", 32'(a_addr), 32'h0001);
    chk("wr_bytesel", 32'(a_sel), 32'b0010);
    chk("wr_wrdata", a_wrdata, 32'hA5A5A5A5);
    step(); p1_req = 0; p1_wr = 0; #1;
    chk("idle_p1_ack", 32'(a_p1_ack), 0);
    chk("idle_bytesel", 32'(a_sel), 0);
    chk("idle_wrdata", a_wrdata, 0);
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      chk("wr_no_rvalid", 32'({a_p0_rvalid, a_p1_rvalid}), 0);
    end

    // CPU byte read of lane 2 of word 1
    step(); p1_req = 1; p1_wr = 0; p1_addr = 17'h00006; #1;
    chk("rd_p1_ack", 32'(a_p1_ack), 1);
    chk("rd_bytesel", 32'(a_sel), 0);
    chk("rd_ram_addr", 32'(a_addr), 32'h0001);
    for (int k = 1; k <= 4; k++) begin
      step(); p1_req = 0; #1;
      chk("rd_lat2_p1_rvalid", 32'(a_p1_rvalid), (k == 3) ? 1 : 0);
      chk("rd_lat1_p1_rvalid", 32'(b_p1_rvalid), (k == 2) ? 1 : 0);
      if (k >= 3) chk("rd_lat2_p1_rdata", 32'(a_p1_rdata), 32'h22);
      if (k >= 2) chk("rd_lat1_p1_rdata", 32'(b_p1_rdata), 32'h22);
    end

    // Video fetch burst of words 0..3
    for (int i = 0; i < 8; i++) begin
      step();
      p0_req = (i < 4);
      p0_addr = 15'(i);
      #1;
      chk("burst_p0_ack", 32'(a_p0_ack), (i < 4) ? 1 : 0);
      chk("burst_bytesel", 32'(a_sel), 0);
      if (i < 4) chk("burst_ram_addr", 32'(a_addr), i);
      chk("burst_p0_rvalid", 32'(a_p0_rvalid), (i >= 3 && i <= 6) ? 1 : 0);
      if (i >= 3 && i <= 6) chk("burst_p0_rdata", a_p0_rdata, exp_w[i-3]);
      chk("burst_p1_rvalid", 32'(a_p1_rvalid), 0);
    end

    // Starvation: p1 wins on the 5th refused cycle, and again after re-raising
    for (int j = 0; j <= 10; j++) begin
      step();
      p0_req = 1; p0_addr = '0;
      p1_req = (j <= 4 || j >= 6); p1_wr = 0; p1_addr = '0;
      #1;
      chk("starve_p1_ack", 32'(a_p1_ack), (j == 4 || j == 10) ? 1 : 0);
      chk("starve_p0_ack", 32'(a_p0_ack), (j == 4 || j == 10) ? 0 : 1);
    end
    step(); p0_req = 0; p1_req = 0; #1;
    for (int k = 0; k < 4; k++) step();

    // Interleaved p1 read (lane 3) then p0 read, low-latency RAM
    step(); p1_req = 1; p1_wr = 0; p1_addr = 17'h00007; #1;
    chk("ilv_p1_ack", 32'(b_p1_ack), 1);
    step(); p1_req = 0; p0_req = 1; p0_addr = 15'h0002; #1;
    chk("ilv_p0_ack", 32'(b_p0_ack), 1);
    chk("ilv_c1_rvalid", 32'({b_p0_rvalid, b_p1_rvalid}), 0);
    step(); p0_req = 0; #1;
    chk("ilv_c2_p1_rvalid", 32'(b_p1_rvalid), 1);
    chk("ilv_c2_p1_rdata", 32'(b_p1_rdata), 32'h11);
    chk("ilv_c2_p0_rvalid", 32'(b_p0_rvalid), 0);
    step(); #1;
    chk("ilv_c3_p0_rvalid", 32'(b_p0_rvalid), 1);
    chk("ilv_c3_p0_rdata", b_p0_rdata, 32'hCAFEBABE);
    chk("ilv_c3_p1_rvalid", 32'(b_p1_rvalid), 0);
    step(); #1;
    chk("ilv_c4_rvalid", 32'({b_p0_rvalid, b_p1_rvalid}), 0);
    for (int k = 0; k < 3; k++) step();

    // Reset with two reads in flight
    step(); p0_req = 1; p0_addr = 15'h0003; #1;
    chk("flush_p0_ack", 32'(a_p0_ack), 1);
    step(); p0_req = 0; p1_req = 1; p1_wr = 0; p1_addr = 17'h00004; #1;
    chk("flush_p1_ack", 32'(a_p1_ack), 1);
    step(); p1_req = 0; rst = 1; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      if (k == 1) rst = 0;
      #1;
      chk("flush_lat2_rvalid", 32'({a_p0_rvalid, a_p1_rvalid}), 0);
      chk("flush_lat1_rvalid", 32'({b_p0_rvalid, b_p1_rvalid}), 0);
      chk("flush_lat2_rdata", a_p0_rdata | 32'(a_p1_rdata), 0);
      chk("flush_lat1_rdata", b_p0_rdata | 32'(b_p1_rdata), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_access_arbiter.md
Name: vram_access_arbiter

Overview:
- Request-side stage feeding the single-port byte-write VRAM: 32-bit words, 4 byte columns, write-first, fixed read latency.
- Arbitrates between two requestors:
  - Port 0: video fetch, word reads, high priority.
  - Port 1: CPU data port, byte reads and writes.
- Issues at most one RAM access per clock and steers write bytes onto the correct column.
- Tracks in-flight reads through a latency-matched tag pipeline and routes returned data to the owning port.

Parameters:
ADDR_WIDTH, 17, byte address width (128 KB VRAM); word address width is ADDR_WIDTH-2
RAM_LATENCY, 2, RAM read latency in clocks (1 = low-latency RAM, 2 = output-registered RAM); legal values 1..2
STARVE_LIMIT, 4, consecutive refused cycles after which port 1 is forced to win one grant; legal values 1..15

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
p0_req  in  1  port 0 read request, held until p0_ack
p0_addr  in  ADDR_WIDTH-2  port 0 word address
p0_ack  out  1  port 0 request issued to RAM this cycle
p0_rdata  out  32  port 0 read word
p0_rvalid  out  1  p0_rdata valid, one-cycle pulse
p1_req  in  1  port 1 request, held with stable fields until p1_ack
p1_wr  in  1  1 = byte write, 0 = byte read
p1_addr  in  ADDR_WIDTH  port 1 byte address
p1_wdata  in  8  port 1 write byte
p1_ack  out  1  port 1 request issued to RAM this cycle
p1_rdata  out  8  port 1 read byte
p1_rvalid  out  1  p1_rdata valid, one-cycle pulse
ram_addr  out  ADDR_WIDTH-2  RAM word address
ram_wrdata  out  32  RAM write data
ram_wrbytesel  out  4  RAM byte-write enables
ram_rddata  in  32  RAM read data

Behaviour:
- Reset is synchronous and active-high on rst; clk is the only clock.
- While rst is high and on the cycle after it:
  - p0_rvalid=0, p1_rvalid=0.
  - p0_rdata=0, p1_rdata=0.
  - Starvation counter=0, tag pipeline cleared.
- Grant logic is combinational in the issue cycle.
  - Default: p0 wins when p0_req=1.
  - p1 wins when p0_req=0, or when starve_cnt==STARVE_LIMIT.
  - p0_ack and p1_ack are never both 1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle p1_req=1 and p1 is not granted.
  - Clears when p1 is granted or p1_req=0.
- Issue encoding:
  - p0 granted: ram_addr=p0_addr, ram_wrbytesel=0.
  - p1 granted: ram_addr=p1_addr[ADDR_WIDTH-1:2].
  - p1 write: ram_wrdata={4{p1_wdata}}, ram_wrbytesel=4'b0001<<p1_addr[1:0].
  - p1 read: ram_wrbytesel=0.
- Idle cycle (no grant): ram_wrbytesel=0, ram_addr=p0_addr, ram_wrdata=0. An idle cycle must never write.
- Tag pipeline, RAM_LATENCY stages:
  - Each issued read pushes {valid=1, port, lane=p1_addr[1:0]}.
  - Writes and idle cycles push valid=0.
- Read return, for a read issued in cycle N:
  - ram_rddata is sampled at cycle N+RAM_LATENCY.
  - Registered outputs pulse in cycle N+RAM_LATENCY+1.
  - Port 0 receives the full word.
  - Port 1 receives byte ram_rddata[8*lane+:8].
- rdata holds its last value when rvalid=0.
- Back-to-back reads are accepted every cycle; throughput is 1 access per clock.
- Write followed by read of the same word in the next cycle: the RAM is write-first, so the arbiter adds no hazard logic, and returned data reflects the write.
- rst asserted mid-operation: in-flight reads are discarded and produce no rvalid. The requestor must re-issue.
- Writes produce no response beyond p1_ack.

Decomposition:
- Shared package vram_pkg:
  - VRAM_DATA_W=32, VRAM_NB_COL=4, VRAM_COL_W=8.
  - Port-id enum {PORT_VIDEO=0, PORT_CPU=1}.
  - Read-tag struct {valid, port, lane[1:0]}.
- One natural sub-module: vram_rd_tag_pipe. It is a parameterised RAM_LATENCY-deep shift register of read tags with synchronous clear; the arbiter instantiates it once.

Test Plan:
- Reset, then single p1 write addr=17'h00005, wdata=8'hA5 → ram_addr=15'h0001, ram_wrbytesel=4'b0010, ram_wrdata=32'hA5A5A5A5, p1_ack=1 for one cycle, no rvalid.
- RAM model holds word 0x0001=32'h11223344; p1 read addr=17'h00006 with RAM_LATENCY=2 → p1_rvalid exactly 3 cycles after p1_ack, p1_rdata=8'h22.
- p0 reads words 0,1,2,3 on consecutive cycles → four p0_acks back-to-back, four consecutive p0_rvalid with matching words in order, ram_wrbytesel=0 throughout.
- p0_req held high continuously, p1_req raised, STARVE_LIMIT=4 → p1 refused 4 cycles, granted on the 5th, p0 granted again the next cycle, starve_cnt back to 0.
- Interleave p1 read (lane 3) and p0 read in adjacent cycles, RAM_LATENCY=1 → each rvalid goes only to its owner port, 2 cycles after the respective ack, with the correct lane extracted.
- Issue two reads, assert rst for one cycle in the following cycle → no p0_rvalid/p1_rvalid ever appears for those reads, and both rvalids and rdata are 0 after reset.
